// File: rtl/shiftreg_sequencer_if.sv
// Requester handshake and shift-register control bundle for shiftreg_sequencer.
// master: the sequencer side; slave: the requesters plus the register harness.
interface shiftreg_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             VALID0;
  logic [WIDTH-1:0] DATA0;
  logic             READY0;
  logic             VALID1;
  logic [WIDTH-1:0] DATA1;
  logic             READY1;
  logic             ENB;
  logic             DIR;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic             S_IN;
  logic             BIT_VALID;
  logic             GNT_ID;
  logic             BUSY;

  modport master (
    input  VALID0, DATA0, VALID1, DATA1,
    output READY0, READY1, ENB, DIR, MODO, D, S_IN, BIT_VALID, GNT_ID, BUSY
  );

  modport slave (
    output VALID0, DATA0, VALID1, DATA1,
    input  READY0, READY1, ENB, DIR, MODO, D, S_IN, BIT_VALID, GNT_ID, BUSY
  );
endinterface

// File: rtl/shiftreg_sequencer.sv
// Round-robin word sequencer for a universal shift register: grants one of two
// requesters, parallel-loads the word, then shifts it out over WIDTH cycles.
module shiftreg_sequencer #(
  parameter int   WIDTH   = 4,
  parameter bit   SHIFT_R = 1'b0,
  parameter logic FILL    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  shiftreg_sequencer_if.master  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             pri_q;
  logic             gnt_q;
  logic             enb_q;
  logic             bv_q;
  logic             busy_q;
  logic [1:0]       modo_q;
  logic [WIDTH-1:0] d_q;

  logic             acc, g, rdy0, rdy1, xfer;
  logic [WIDTH-1:0] word_d;

  // Accept window and arbitration; READY is held low while reset is asserted.
  always_comb begin
    acc    = RESET_L && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST)));
    g      = (bus.VALID0 && bus.VALID1) ? pri_q : bus.VALID1;
    rdy0   = acc && bus.VALID0 && !g;
    rdy1   = acc && bus.VALID1 && g;
    xfer   = rdy0 || rdy1;
    word_d = g ? bus.DATA1 : bus.DATA0;
  end

  // Sequencer FSM with registered register-control outputs.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      gnt_q   <= 1'b0;
      enb_q   <= 1'b0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      modo_q  <= 2'b00;
      d_q     <= '0;
    end else if (xfer) begin
      // Granted word goes straight onto D for the one-cycle parallel load.
      state_q <= LOAD;
      cnt_q   <= '0;
      pri_q   <= ~g;
      gnt_q   <= g;
      d_q     <= word_d;
      enb_q   <= 1'b1;
      modo_q  <= 2'b10;
      bv_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          enb_q   <= 1'b1;
          modo_q  <= 2'b01;
          bv_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            enb_q   <= 1'b0;
            modo_q  <= 2'b00;
            bv_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          enb_q   <= 1'b0;
          modo_q  <= 2'b00;
          bv_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.READY0    = rdy0;
  assign bus.READY1    = rdy1;
  assign bus.ENB       = enb_q;
  assign bus.DIR       = SHIFT_R;
  assign bus.MODO      = modo_q;
  assign bus.D         = d_q;
  assign bus.S_IN      = FILL;
  assign bus.BIT_VALID = bv_q;
  assign bus.GNT_ID    = gnt_q;
  assign bus.BUSY      = busy_q;

endmodule
